// File: rtl/pipe_skid_stage.sv
// Valid/ready pipeline stage with a one-entry skid buffer, flush-to-bubble and a
// saturating back-pressure counter. All outputs come straight from flops.
module pipe_skid_stage #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [1:0]        occupancy_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              in_ready_q;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic              accept, pop;

  assign accept = in_valid_i & in_ready_q;
  assign pop    = (state_q != EMPTY) & out_ready_i;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: if (accept) begin
        state_d = ONE;
        main_d  = in_data_i;
      end
      ONE: begin
        if (accept && pop) begin
          main_d = in_data_i;
        end else if (accept) begin
          state_d = FULL;
          skid_d  = in_data_i;
        end else if (pop) begin
          state_d = EMPTY;
          main_d  = '0;
        end
      end
      FULL: if (pop) begin
        state_d = ONE;
        main_d  = skid_q;
        skid_d  = '0;
      end
      default: begin
        state_d = EMPTY;
        main_d  = '0;
        skid_d  = '0;
      end
    endcase
    // Flush wins over any same-cycle accept; the incoming word is dropped.
    if (flush_i) begin
      state_d = EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((state_q != EMPTY) && !out_ready_i && (stall_cnt_q != {CNT_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= (state_d != FULL);
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = (state_q != EMPTY);
  assign out_data_o  = main_q;
  assign occupancy_o = state_q;
  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Bench for pipe_skid_stage: a queue reference model checked every cycle, plus a
// table of directed vectors and hand-written streaming/saturation sequences.
module tb_pipe_skid_stage;
  localparam int DW = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_i, flush_i, in_valid_i, in_ready_o, out_valid_o, out_ready_i;
  logic [DW-1:0] in_data_i, out_data_o;
  logic [1:0]    occupancy_o;
  logic [CW-1:0] stall_cnt_o;

  int checks = 0;
  int failures = 0;
  logic [DW-1:0] mq[$];
  int mcnt = 0;

  pipe_skid_stage #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
    .occupancy_o(occupancy_o), .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk = ~clk;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endfunction

  // One clock: drive inputs, step the reference queue, compare after the edge.
  task automatic cyc(input logic r, input logic f, input logic iv,
                     input logic [DW-1:0] d, input logic ordy);
    int  n;
    bit  acc, pp;
    rst_i = r; flush_i = f; in_valid_i = iv; in_data_i = d; out_ready_i = ordy;
    n   = mq.size();
    acc = iv && (n < 2);
    pp  = (n > 0) && ordy;
    @(posedge clk);
    #1;
    if (r) begin
      mq.delete();
      mcnt = 0;
    end else begin
      if (n > 0 && !ordy && mcnt != 15) mcnt++;
      if (f) mq.delete();
      else begin
        if (pp) void'(mq.pop_front());
        if (acc) mq.push_back(d);
      end
    end
    chk("sb_out_valid", {31'd0, out_valid_o}, {31'd0, mq.size() > 0});
    chk("sb_out_data", out_data_o, (mq.size() > 0) ? mq[0] : 32'd0);
    chk("sb_in_ready", {31'd0, in_ready_o}, {31'd0, mq.size() < 2});
    chk("sb_occupancy", {30'd0, occupancy_o}, mq.size());
    chk("sb_stall_cnt", {28'd0, stall_cnt_o}, mcnt);
  endtask

  typedef struct {
    logic r, f, iv; logic [DW-1:0] d; logic ordy;
    logic eov; logic [DW-1:0] edat; logic eir; logic [1:0] eocc; logic [CW-1:0] ecnt;
  } vec_t;

  vec_t vt[$];

  initial begin
    in_valid_i = 0; in_data_i = 0; out_ready_i = 0; flush_i = 0; rst_i = 1;

    // Reset with random other inputs
    cyc(1'b1, 1'($urandom), 1'($urandom), $urandom, 1'($urandom));
    chk("rst_out_valid", {31'd0, out_valid_o}, 32'd0);
    chk("rst_out_data", out_data_o, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready_o}, 32'd1);
    chk("rst_occupancy", {30'd0, occupancy_o}, 32'd0);
    chk("rst_stall_cnt", {28'd0, stall_cnt_o}, 32'd0);

    // Back-pressure, flush in FULL, flush with pop, reset mid-transfer.
    //            r  f  iv d      rdy  ov dat    ir occ cnt
    vt.push_back('{0, 0, 1, 'hA,  1,   1, 'hA,   1, 1,  0});
    vt.push_back('{0, 0, 1, 'hB,  0,   1, 'hA,   0, 2,  1});
    vt.push_back('{0, 0, 1, 'hC,  0,   1, 'hA,   0, 2,  2});
    vt.push_back('{0, 0, 1, 'hC,  1,   1, 'hB,   1, 1,  2});
    vt.push_back('{0, 0, 1, 'hC,  1,   1, 'hC,   1, 1,  2});
    vt.push_back('{0, 0, 0, 'h0,  1,   0, 'h0,   1, 0,  2});
    vt.push_back('{0, 0, 1, 'h11, 0,   1, 'h11,  1, 1,  2});
    vt.push_back('{0, 0, 1, 'h22, 0,   1, 'h11,  0, 2,  3});
    vt.push_back('{0, 1, 1, 'h33, 0,   0, 'h0,   1, 0,  4});
    vt.push_back('{0, 0, 0, 'h0,  1,   0, 'h0,   1, 0,  4});
    vt.push_back('{0, 0, 1, 'h44, 1,   1, 'h44,  1, 1,  4});
    vt.push_back('{0, 1, 1, 'h55, 1,   0, 'h0,   1, 0,  4});
    vt.push_back('{0, 0, 1, 'h66, 0,   1, 'h66,  1, 1,  4});
    vt.push_back('{0, 0, 1, 'h77, 0,   1, 'h66,  0, 2,  5});
    vt.push_back('{1, 1, 1, 'h88, 0,   0, 'h0,   1, 0,  0});
    vt.push_back('{0, 0, 0, 'h0,  1,   0, 'h0,   1, 0,  0});
    for (int i = 0; i < vt.size(); i++) begin
      cyc(vt[i].r, vt[i].f, vt[i].iv, vt[i].d, vt[i].ordy);
      chk($sformatf("vec%0d_out_valid", i), {31'd0, out_valid_o}, {31'd0, vt[i].eov});
      chk($sformatf("vec%0d_out_data", i), out_data_o, vt[i].edat);
      chk($sformatf("vec%0d_in_ready", i), {31'd0, in_ready_o}, {31'd0, vt[i].eir});
      chk($sformatf("vec%0d_occupancy", i), {30'd0, occupancy_o}, {30'd0, vt[i].eocc});
      chk($sformatf("vec%0d_stall_cnt", i), {28'd0, stall_cnt_o}, {28'd0, vt[i].ecnt});
    end

    // Streaming 0x100..0x10F with out_ready held high
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, 1'b0, 1'b1, 32'h100 + i, 1'b1);
      chk("stream_data", out_data_o, 32'h100 + i);
      chk("stream_valid", {31'd0, out_valid_o}, 32'd1);
      chk("stream_in_ready", {31'd0, in_ready_o}, 32'd1);
      chk("stream_stall_cnt", {28'd0, stall_cnt_o}, 32'd0);
    end
    cyc(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    chk("stream_drained", {31'd0, out_valid_o}, 32'd0);

    // Saturation: one held word, consumer stalled for 20 cycles
    cyc(1'b0, 1'b0, 1'b1, 32'h99, 1'b0);
    for (int k = 1; k <= 20; k++) begin
      cyc(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
      chk("sat_stall_cnt", {28'd0, stall_cnt_o}, (k < 15) ? k : 15);
    end
    cyc(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);

    // Random traffic against the reference queue
    for (int i = 0; i < 10000; i++)
      cyc(1'b0, ($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0),
          $urandom, ($urandom_range(0, 3) != 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pipe_skid_stage.md
# pipe_skid_stage

Parametrised pipeline stage register that replaces fixed enable/clear inter-stage registers with a valid/ready handshake and a one-entry skid buffer. It passes an opaque DATA_W-bit stage bundle (PC, ALU result, control bits, instruction word, store data) from one stage to the next. Back-pressure stalls the producer through a registered ready, and flush inserts a bubble. A saturating counter records back-pressure cycles for performance debug.

## Interface
- DATA_W, 32, width of the stage bundle carried (≥1)
- CNT_W, 16, width of the stall-cycle counter (≥1)

- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- flush  in  1  discard all held entries (bubble insert)
- in_valid  in  1  producer offers in_data
- in_ready  out  1  stage can accept; registered, never combinationally dependent on out_ready
- in_data  in  DATA_W  producer bundle
- out_valid  out  1  out_data holds a valid entry
- out_ready  in  1  consumer accepts out_data this cycle
- out_data  out  DATA_W  consumer bundle; all zero whenever out_valid=0
- occupancy  out  2  held entries: 0, 1 or 2
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating

## Operation
- Storage: main slot (drives out_*) and skid slot. Each slot has a data register and a valid bit.
- Define accept = in_valid & in_ready and pop = out_valid & out_ready.
- in_ready = ~skid_valid, taken directly from a flop.
- States are named by occupancy:
  - EMPTY (0): accept → ONE, main ← in_data.
  - ONE (1): accept & pop → ONE, main ← in_data. accept & ~pop → FULL, skid ← in_data. ~accept & pop → EMPTY. Otherwise hold.
  - FULL (2): no accept is possible. pop → ONE, main ← skid, skid cleared. Otherwise hold.
- Ordering is strictly FIFO. Entries are never dropped or duplicated except by flush or rst.
- Any slot that becomes invalid has its data register cleared to 0. out_data is therefore 0 whenever out_valid=0.
- flush:
  - Next cycle: both valid bits 0, both data registers 0, occupancy 0, in_ready 1.
  - Overrides any same-cycle accept; that input is discarded.
  - A same-cycle pop still counts as consumed by the consumer.
  - flush does not touch stall_cnt.
- stall_cnt:
  - Increments by 1 each cycle with out_valid & ~out_ready.
  - Holds at 2^CNT_W−1 once reached; no wrap-around.
- rst has priority over flush and the handshake. On the next edge:
  - out_valid=0, out_data=0, occupancy=0.
  - in_ready=1, stall_cnt=0.
  - Skid slot cleared.
- rst asserted mid-transfer discards all held entries.

## Timing
- Latency: a word accepted into an EMPTY stage is presented on out_data with out_valid=1 on the next cycle.
- Throughput: 1 word/cycle sustained while out_ready=1.
- When out_ready falls with the stage in ONE and accept occurring, the stage goes FULL. in_ready drops in the following cycle. No word is lost, since the skid slot absorbs the in-flight word.
- After out_ready rises from FULL:
  - Cycle of pop: main ← skid.
  - Next cycle: in_ready=1.
- out_valid, out_data, occupancy, in_ready and stall_cnt are all registered outputs with no combinational input-to-output paths.
- Simultaneous accept & pop in ONE keeps occupancy at 1.
- Simultaneous flush & rst: rst behaviour applies.

## Test plan
- Reset: drive rst 1 cycle with random inputs → out_valid=0, out_data=0, in_ready=1, occupancy=0, stall_cnt=0.
- Streaming: DATA_W=32, out_ready=1, send 0x100..0x10F back-to-back → identical sequence out, each one cycle after accept; in_ready never 0; stall_cnt stays 0.
- Back-pressure: send 0xA, 0xB, 0xC on consecutive cycles with out_ready=0 from the second cycle →
  - occupancy reaches 2 and in_ready goes 0.
  - 0xC is held by the producer.
  - out_ready=1 for 3 cycles then yields 0xA, 0xB, 0xC in order.
  - stall_cnt equals the number of stalled cycles.
- Flush: with occupancy=2 holding 0x11, 0x22, assert flush with in_valid=1, in_data=0x33 → next cycle out_valid=0, out_data=0, occupancy=0, in_ready=1; 0x33 never appears.
- Saturation: CNT_W=4, hold out_valid=1 and out_ready=0 for 20 cycles → stall_cnt reads 15 and stays 15.
- Random: random in_valid/out_ready/flush over 10k cycles, scoreboard checked against a reference queue → no loss, duplication or reordering outside flush.
